inst_loader: RTL

Writer-side companion to the instruction fetch path. Lets an operator enter 32-bit instruction words into the instruction memory one byte at a time, using the 8 board switches and a single push button. Each debounced button release commits the switch byte into the next byte lane. After four bytes, the block issues a single-cycle word write to the memory's write port and advances the word address. It drives the memory port (`wea`/`addra`/`dina`) while the fetch side holds the write enable low.

---
 rtl/inst_loader.sv | 86 ++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Byte-at-a-time instruction word loader: debounced button commits switch bytes,
// every fourth byte issues a one-cycle word write and advances the word address.
module inst_loader #(
  parameter int ADDR_W   = 6,
  parameter int DEBOUNCE = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Button,
  input  logic [7:0]        Sw,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [7:0]        LED,
  output logic              Full
);

  localparam logic [2:0] B0   = 3'd0;
  localparam logic [2:0] B1   = 3'd1;
  localparam logic [2:0] B2   = 3'd2;
  localparam logic [2:0] B3   = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] FULL = 3'd5;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [DEBOUNCE:0] r_buf;
  logic              r_deb;
  logic              r_deb_d;
  logic [2:0]        r_state;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_addr;

  logic [DEBOUNCE:0] w_buf_nxt;
  logic              w_commit;

  // The filter decides on the shifted-in value so deb moves on the
  // DEBOUNCE+1-th consecutive sample itself (needs DEBOUNCE >= 1).
  assign w_buf_nxt = {r_buf[DEBOUNCE-1:0], Button};
  assign w_commit  = r_deb_d & ~r_deb;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_buf   <= '0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_state <= B0;
      r_word  <= '0;
      r_addr  <= '0;
    end else begin
      r_buf   <= w_buf_nxt;
      r_deb_d <= r_deb;
      if (&w_buf_nxt)
        r_deb <= 1'b1;
      else if (~|w_buf_nxt)
        r_deb <= 1'b0;

      case (r_state)
        B0, B1, B2, B3: begin
          if (w_commit) begin
            r_word[{r_state[1:0], 3'b000} +: 8] <= Sw;
            r_state <= (r_state == B3) ? WR : r_state + 3'd1;
          end
        end
        WR: begin
          if (r_addr == ADDR_MAX) begin
            r_state <= FULL;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= B0;
          end
        end
        FULL:    r_state <= FULL;
        default: r_state <= B0;
      endcase
    end
  end

  // Lane is the low two state bits; WR decodes to lane 0.
  assign mem_we   = (r_state == WR);
  assign Full     = (r_state == FULL);
  assign mem_addr = r_addr;
  assign mem_din  = r_word;
  assign LED      = Full ? 8'hFF : {r_state[1:0], r_addr[5:0]};

endmodule
